// File: rtl/ap_mult_pkg.sv
// Shared sizing helpers for the approximate Wallace-tree multiplier: tree depth,
// pipeline stage boundaries and row-count bookkeeping.
package ap_mult_pkg;

    localparam int unsigned DW_MAX   = 32;
    localparam int unsigned PIPE_MAX = 4;

    typedef int unsigned col_height_t [2*DW_MAX];

    function automatic int unsigned clog(input int unsigned v);
        int unsigned r;
        r = 0;
        while (r < 32 && (64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Rows remaining at the input of Wallace level lvl, starting from n0 rows.
    function automatic int unsigned row_count(input int unsigned n0, input int unsigned lvl);
        int unsigned n;
        n = n0;
        for (int unsigned l = 0; l < lvl; l++) n = 2 * (n / 3) + (n % 3);
        return n;
    endfunction

    function automatic int unsigned wall_levels(input int unsigned dw);
        int unsigned n;
        int unsigned l;
        n = dw;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            l++;
        end
        return l;
    endfunction

    // First Wallace level handled by pipeline stage stg; stg == pipe gives the level count.
    function automatic int unsigned stage_split(input int unsigned levels, input int unsigned pipe,
                                                input int unsigned stg);
        return (levels * stg) / pipe;
    endfunction

endpackage

// File: rtl/ap_csa_row.sv
// One row of 3:2 counters; the carry vector is returned unshifted.
module ap_csa_row #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/ap_unsi_wall_pipe.sv
// Pipelined approximate unsigned Wallace-tree multiplier with a global-stall handshake.
// Define AP_RUNTIME_MODE_EN to add a per-transaction apx_en input (0 = exact product).
module ap_unsi_wall_pipe
    import ap_mult_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned APX_COLS = 4,
    parameter int unsigned PIPE_STG = 2
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef AP_RUNTIME_MODE_EN
    input  logic            apx_en,
`endif
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [DW-1:0]   muld,
    input  logic [DW-1:0]   mulr,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [2*DW-1:0] res
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned WL = wall_levels(DW);

    logic                apx_on;
    logic                stall;
    logic [PIPE_STG-1:0] vld_q, vld_nxt;
    logic [PW-1:0]       pp_rows [DW];
    logic [PW-1:0]       or_bits;
    logic [PW-1:0]       lin     [WL][DW];
    logic [PW-1:0]       lout    [WL][DW];
    logic [PW-1:0]       sin     [PIPE_STG][DW];
    logic [PW-1:0]       sout    [PIPE_STG][DW];
    logic [PW-1:0]       orv     [PIPE_STG];
    logic [PW-1:0]       res_q;

`ifdef AP_RUNTIME_MODE_EN
    assign apx_on = apx_en;
`else
    assign apx_on = 1'b1;
`endif

    assign stall   = vld_q[PIPE_STG-1] & ~out_rdy;
    assign in_rdy  = ~stall;
    assign out_vld = vld_q[PIPE_STG-1];
    assign res     = res_q;

    // Low columns collapse to a single OR bit each; only the rest feeds the tree.
    always_comb begin
        or_bits = '0;
        for (int unsigned j = 0; j < DW; j++) begin
            pp_rows[j] = '0;
            for (int unsigned i = 0; i < DW; i++) begin
                if (apx_on && (i + j) < APX_COLS) begin
                    or_bits[i+j] = or_bits[i+j] | (muld[i] & mulr[j]);
                end else begin
                    pp_rows[j][i+j] = muld[i] & mulr[j];
                end
            end
        end
    end

    always_comb begin
        vld_nxt    = vld_q << 1;
        vld_nxt[0] = in_vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q <= vld_nxt;
        end
    end

    for (genvar r = 0; r < DW; r++) begin : g_sin0
        assign sin[0][r] = pp_rows[r];
    end
    assign orv[0] = or_bits;

    for (genvar l = 0; l < WL; l++) begin : g_lvl
        localparam int unsigned N = row_count(DW, l);
        localparam int unsigned G = N / 3;
        localparam int unsigned K = N - 3 * G;
        for (genvar g = 0; g < G; g++) begin : g_csa
            logic [PW-1:0] cy;
            ap_csa_row #(.W(PW)) u_csa (
                .a  (lin[l][3*g]),
                .b  (lin[l][3*g+1]),
                .c  (lin[l][3*g+2]),
                .s  (lout[l][2*g]),
                .co (cy)
            );
            assign lout[l][2*g+1] = cy << 1;
        end
        for (genvar r = 2 * G; r < DW; r++) begin : g_pass
            if (r < 2 * G + K) begin : g_keep
                assign lout[l][r] = lin[l][r+G];
            end else begin : g_zero
                assign lout[l][r] = '0;
            end
        end
    end

    for (genvar s = 0; s < PIPE_STG; s++) begin : g_stg
        localparam int unsigned B0 = stage_split(WL, PIPE_STG, s);
        localparam int unsigned B1 = stage_split(WL, PIPE_STG, s + 1);

        for (genvar l = B0; l < B1; l++) begin : g_lin
            for (genvar r = 0; r < DW; r++) begin : g_row
                if (l == B0) begin : g_first
                    assign lin[l][r] = sin[s][r];
                end else begin : g_chain
                    assign lin[l][r] = lout[l-1][r];
                end
            end
        end

        for (genvar r = 0; r < DW; r++) begin : g_out
            if (B1 > B0) begin : g_tree
                assign sout[s][r] = lout[B1-1][r];
            end else begin : g_thru
                assign sout[s][r] = sin[s][r];
            end
        end

        if (s < PIPE_STG - 1) begin : g_mid
            logic [PW-1:0] rows_q [DW];
            logic [PW-1:0] or_q;
            always_ff @(posedge clk) begin
                if (!stall) begin
                    for (int unsigned r = 0; r < DW; r++) rows_q[r] <= sout[s][r];
                    or_q <= orv[s];
                end
            end
            for (genvar r = 0; r < DW; r++) begin : g_fwd
                assign sin[s+1][r] = rows_q[r];
            end
            assign orv[s+1] = or_q;
        end else begin : g_last
            // Final carry-propagate add; the exact part has zeros under the OR columns.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q <= '0;
                end else if (!stall) begin
                    res_q <= (sout[s][0] + sout[s][1]) | orv[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_ap_unsi_wall_pipe.sv
// Scoreboard bench: approximate (APX_COLS=4) and exact (APX_COLS=0) instances share stimulus.
module tb_ap_unsi_wall_pipe;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        out_rdy = 1'b1;
    logic [7:0]  muld = '0;
    logic [7:0]  mulr = '0;
    logic        in_rdy0, in_rdy1, out_vld0, out_vld1;
    logic [15:0] res0, res1;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] e0;
        logic [15:0] e1;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ap_unsi_wall_pipe #(.DW(8), .APX_COLS(4), .PIPE_STG(P)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef AP_RUNTIME_MODE_EN
        .apx_en  (1'b1),
`endif
        .in_vld  (in_vld),
        .in_rdy  (in_rdy0),
        .muld    (muld),
        .mulr    (mulr),
        .out_vld (out_vld0),
        .out_rdy (out_rdy),
        .res     (res0)
    );

    ap_unsi_wall_pipe #(.DW(8), .APX_COLS(0), .PIPE_STG(P)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef AP_RUNTIME_MODE_EN
        .apx_en  (1'b1),
`endif
        .in_vld  (in_vld),
        .in_rdy  (in_rdy1),
        .muld    (muld),
        .mulr    (mulr),
        .out_vld (out_vld1),
        .out_rdy (out_rdy),
        .res     (res1)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", nm, got, want);
    endtask

    // Behavioural reference: OR of low columns, exact weighted sum of the rest.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input int apx);
        logic [31:0] acc;
        logic [15:0] orb;
        acc = '0;
        orb = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (a[i] && b[j]) begin
                    if (i + j < apx) orb[i+j] = 1'b1;
                    else acc = acc + (32'd1 << (i + j));
                end
        return acc[15:0] | orb;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic rdy,
                        input logic [15:0] e0, input logic [15:0] e1, input bit lat,
                        output int waits);
        @(negedge clk);
        muld = a;
        mulr = b;
        in_vld = 1'b1;
        out_rdy = rdy;
        #1;
        waits = 0;
        while (!in_rdy0 && waits < 100) begin
            @(negedge clk);
            out_rdy = 1'b1;
            #1;
            waits++;
        end
        if (!in_rdy0) begin
            check("send_timeout", 32'(in_rdy0), 32'd1);
            in_vld = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back('{e0, e1, lat ? cyc + P : -1});
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) begin
            @(negedge clk);
            in_vld = 1'b0;
            out_rdy = rdy;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_vld0 && out_rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(out_vld0), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("res_apx", 32'(res0), 32'(e.e0));
                    check("res_exact", 32'(res1), 32'(e.e1));
                    check("vld_exact", 32'(out_vld1), 32'd1);
                    if (e.lat >= 0) check("latency", cyc, e.lat);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        logic [7:0] a, b;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_vld", 32'(out_vld0), 32'd0);
        check("rst_in_rdy", 32'(in_rdy0), 32'd1);
        check("rst_res", 32'(res0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(8'h0F, 8'h0F, 1'b1, 16'h00BF, 16'h00E1, 1'b1, w);
        idle(4, 1'b1);
        send(8'hFF, 8'hFF, 1'b1, 16'hFDDF, 16'hFE01, 1'b1, w);
        idle(4, 1'b1);

        send(8'd0, 8'd5, 1'b1, 16'd0, 16'd0, 1'b1, w);
        check("rdy_stream0", w, 0);
        send(8'd3, 8'd7, 1'b1, 16'd15, 16'd21, 1'b1, w);
        check("rdy_stream1", w, 0);
        send(8'd255, 8'd1, 1'b1, 16'd255, 16'd255, 1'b1, w);
        check("rdy_stream2", w, 0);
        idle(4, 1'b1);

        // Stall: two results fill the pipe, a third is held at the input.
        send(8'h0F, 8'h0F, 1'b0, 16'h00BF, 16'h00E1, 1'b0, w);
        send(8'd3, 8'd7, 1'b0, 16'd15, 16'd21, 1'b0, w);
        repeat (5) begin
            @(negedge clk);
            muld = 8'd255;
            mulr = 8'd1;
            in_vld = 1'b1;
            out_rdy = 1'b0;
            #1;
            check("stall_in_rdy", 32'(in_rdy0), 32'd0);
            check("stall_out_vld", 32'(out_vld0), 32'd1);
            check("stall_res", 32'(res0), 32'h00BF);
        end
        send(8'd255, 8'd1, 1'b1, 16'd255, 16'd255, 1'b0, w);
        idle(5, 1'b1);
        check("stall_drain", sb.size(), 0);

        // Reset with two results in flight.
        send(8'h0F, 8'h0F, 1'b1, 16'h00BF, 16'h00E1, 1'b0, w);
        send(8'hFF, 8'hFF, 1'b1, 16'hFDDF, 16'hFE01, 1'b0, w);
        @(negedge clk);
        in_vld = 1'b0;
        #1;
        rst_n = 1'b0;
        #2;
        check("mrst_out_vld", 32'(out_vld0), 32'd0);
        check("mrst_res_apx", 32'(res0), 32'd0);
        check("mrst_res_exact", 32'(res1), 32'd0);
        check("mrst_in_rdy", 32'(in_rdy0), 32'd1);
        check("mrst_in_rdy1", 32'(in_rdy1), 32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("post_rst_vld", 32'(out_vld0), 32'd0);
        end

        for (int n = 0; n < 10000; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (n % 16 == 0) a = 8'd0;
            send(a, b, ($urandom_range(0, 3) != 0), model(a, b, 4), model(a, b, 0), 1'b0, w);
        end
        idle(10, 1'b1);
        check("final_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
